// File: rtl/axi_lite_xbar_1to2.sv
// axi_lite_xbar_1to2
// Address-decoding AXI-lite demux: one upstream master to two downstream slaves
// (s0 = SRAM, s1 = UART) plus an internal decode-error responder. Read and
// write paths are independent FSMs. Each path carries one transaction at a time
// and holds its route until the response handshake completes.
module axi_lite_xbar_1to2 #(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_03F8,
  parameter logic [31:0] S1_MASK = 32'hFFFF_FFF8
) (
  input  logic        clk,
  input  logic        rst_n,
  // master read address / data
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  // master write address / data / response
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  // slave 0
  output logic [31:0] s0_araddr,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  output logic [31:0] s0_awaddr,
  output logic        s0_awvalid,
  input  logic        s0_awready,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  output logic        s0_wvalid,
  input  logic        s0_wready,
  input  logic [1:0]  s0_bresp,
  input  logic        s0_bvalid,
  output logic        s0_bready,
  // slave 1
  output logic [31:0] s1_araddr,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  output logic [31:0] s1_awaddr,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  input  logic [1:0]  s1_bresp,
  input  logic        s1_bvalid,
  output logic        s1_bready
);

  localparam logic [1:0] TGT_S0  = 2'd0;
  localparam logic [1:0] TGT_S1  = 2'd1;
  localparam logic [1:0] TGT_ERR = 2'd2;
  localparam logic [1:0] DECERR  = 2'b11;

  typedef enum logic [2:0] {R_IDLE, R_ADDR, R_DATA, R_EADDR, R_EDATA} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_RESP, W_EADDR, W_ERESP} wr_state_t;

  // S0 wins on overlap; anything unmatched goes to the error responder.
  function automatic logic [1:0] decode(input logic [31:0] addr);
    logic [1:0] tgt;
    if ((addr & S0_MASK) == S0_BASE) begin
      tgt = TGT_S0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      tgt = TGT_S1;
    end else begin
      tgt = TGT_ERR;
    end
    return tgt;
  endfunction

  rd_state_t  rd_state_r;
  wr_state_t  wr_state_r;
  logic       rsel_r;      // 0 = s0, 1 = s1 (meaningful in R_ADDR/R_DATA)
  logic       wsel_r;      // 0 = s0, 1 = s1 (meaningful in W_ADDR/W_RESP)
  logic       aw_done_r;
  logic       w_done_r;
  logic [1:0] ar_tgt_s;
  logic [1:0] aw_tgt_s;
  logic       aw_all_s;
  logic       w_all_s;

  assign ar_tgt_s = decode(m_araddr);
  assign aw_tgt_s = decode(m_awaddr);
  // a channel counts as done once it has handshaked in this or an earlier cycle
  assign aw_all_s = aw_done_r | (m_awvalid & m_awready);
  assign w_all_s  = w_done_r  | (m_wvalid  & m_wready);

  // Address and write payload fan out to both slaves; only valids are steered.
  assign s0_araddr = m_araddr;
  assign s1_araddr = m_araddr;
  assign s0_awaddr = m_awaddr;
  assign s1_awaddr = m_awaddr;
  assign s0_wdata  = m_wdata;
  assign s1_wdata  = m_wdata;
  assign s0_wstrb  = m_wstrb;
  assign s1_wstrb  = m_wstrb;

  // Read path state: decode once, then hold the route until R completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_r <= R_IDLE;
      rsel_r     <= 1'b0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (m_arvalid) begin
            rsel_r     <= (ar_tgt_s == TGT_S1);
            rd_state_r <= (ar_tgt_s == TGT_ERR) ? R_EADDR : R_ADDR;
          end
        end
        R_ADDR:  if (m_arvalid && m_arready) rd_state_r <= R_DATA;
        R_DATA:  if (m_rvalid && m_rready)   rd_state_r <= R_IDLE;
        R_EADDR: rd_state_r <= R_EDATA;
        R_EDATA: if (m_rready)               rd_state_r <= R_IDLE;
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Read path steering: connect master to the selected slave or the error responder.
  always_comb begin
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 32'h0000_0000;
    m_rresp    = 2'b00;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_rready  = 1'b0;
    case (rd_state_r)
      R_ADDR: begin
        if (rsel_r) begin
          s1_arvalid = m_arvalid;
          m_arready  = s1_arready;
        end else begin
          s0_arvalid = m_arvalid;
          m_arready  = s0_arready;
        end
      end
      R_DATA: begin
        if (rsel_r) begin
          m_rvalid  = s1_rvalid;
          m_rdata   = s1_rdata;
          m_rresp   = s1_rresp;
          s1_rready = m_rready;
        end else begin
          m_rvalid  = s0_rvalid;
          m_rdata   = s0_rdata;
          m_rresp   = s0_rresp;
          s0_rready = m_rready;
        end
      end
      R_EADDR: m_arready = 1'b1;
      R_EDATA: begin
        m_rvalid = 1'b1;
        m_rresp  = DECERR;
      end
      default: m_arready = 1'b0;
    endcase
  end

  // Write path state: decode on AW, collect AW and W in any order, then route B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_r <= W_IDLE;
      wsel_r     <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          if (m_awvalid) begin
            wsel_r     <= (aw_tgt_s == TGT_S1);
            wr_state_r <= (aw_tgt_s == TGT_ERR) ? W_EADDR : W_ADDR;
          end
        end
        W_ADDR, W_EADDR: begin
          aw_done_r <= aw_all_s;
          w_done_r  <= w_all_s;
          if (aw_all_s && w_all_s) begin
            wr_state_r <= (wr_state_r == W_EADDR) ? W_ERESP : W_RESP;
          end
        end
        W_RESP:  if (m_bvalid && m_bready) wr_state_r <= W_IDLE;
        W_ERESP: if (m_bready)             wr_state_r <= W_IDLE;
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  // Write path steering: a channel's valid/ready is masked once it has completed.
  always_comb begin
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    m_bvalid   = 1'b0;
    m_bresp    = 2'b00;
    s0_awvalid = 1'b0;
    s1_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
    s1_wvalid  = 1'b0;
    s0_bready  = 1'b0;
    s1_bready  = 1'b0;
    case (wr_state_r)
      W_ADDR: begin
        if (wsel_r) begin
          s1_awvalid = m_awvalid & ~aw_done_r;
          m_awready  = s1_awready & ~aw_done_r;
          s1_wvalid  = m_wvalid & ~w_done_r;
          m_wready   = s1_wready & ~w_done_r;
        end else begin
          s0_awvalid = m_awvalid & ~aw_done_r;
          m_awready  = s0_awready & ~aw_done_r;
          s0_wvalid  = m_wvalid & ~w_done_r;
          m_wready   = s0_wready & ~w_done_r;
        end
      end
      W_RESP: begin
        if (wsel_r) begin
          m_bvalid  = s1_bvalid;
          m_bresp   = s1_bresp;
          s1_bready = m_bready;
        end else begin
          m_bvalid  = s0_bvalid;
          m_bresp   = s0_bresp;
          s0_bready = m_bready;
        end
      end
      W_EADDR: begin
        m_awready = ~aw_done_r;
        m_wready  = ~w_done_r;
      end
      W_ERESP: begin
        m_bvalid = 1'b1;
        m_bresp  = DECERR;
      end
      default: m_awready = 1'b0;
    endcase
  end

endmodule
